// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the programmable clock divider bank.
package clkdiv_pkg;

  localparam int CNT_W_DEF = 27;
  localparam int NCH_DEF   = 4;
  localparam int DIV_W_DEF = 16;

  // Bits needed to address n channels, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One programmable divider channel: tick enable every div cycles plus a
// 50%-duty square wave. Run-time divisor changes on a running channel are
// staged and take effect on a tick boundary so no period is ever truncated.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync_req,
  output logic             tick,
  output logic             sq,
  output logic             pending
);

  logic             en;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] cnt;
  logic             active;

  // div is only decremented when nonzero, so the compare cannot underflow.
  assign active = en && (div != '0);
  assign tick   = active && (cnt == div - DIV_W'(1));

  // Counter, square wave and staging state; sync wins over everything,
  // then immediate writes, then normal counting with staged apply on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      div      <= '0;
      pend_div <= '0;
      cnt      <= '0;
      sq       <= 1'b0;
      pending  <= 1'b0;
    end else if (sync_req) begin
      cnt <= '0;
      sq  <= 1'b0;
      if (wr) begin
        en      <= cfg_en;
        div     <= cfg_div;
        pending <= 1'b0;
      end else if (pending) begin
        div     <= pend_div;
        pending <= 1'b0;
      end
    end else if (wr && (!cfg_en || !active)) begin
      en      <= cfg_en;
      div     <= cfg_div;
      cnt     <= '0;
      sq      <= 1'b0;
      pending <= 1'b0;
    end else begin
      // A write reaching here targets a running channel; pending was 0.
      if (wr) begin
        pend_div <= cfg_div;
        pending  <= 1'b1;
      end
      if (!active) begin
        cnt <= '0;
        sq  <= 1'b0;
      end else if (tick) begin
        cnt <= '0;
        if (pending) begin
          div     <= pend_div;
          pending <= 1'b0;
          sq      <= (pend_div == '0) ? 1'b0 : ~sq;
        end else begin
          sq <= ~sq;
        end
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Free-running tap counter plus NCH programmable divider channels with a
// valid/ready config port and a global phase-sync request.
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int CH_W  = clog2_min1(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] taps,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync_req,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;

  // Free-running tap counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taps <= '0;
    else        taps <= taps + CNT_W'(1);
  end

  // Ready follows the addressed channel; unmapped channel numbers are
  // always ready and match no write strobe, so they are silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr[g]),
      .cfg_div  (cfg_div),
      .cfg_en   (cfg_en),
      .sync_req (sync_req),
      .tick     (tick[g]),
      .sq       (sq[g]),
      .pending  (pending[g])
    );
  end

endmodule
